// File: rtl/mux_sequencer_if.sv
// rtl/mux_sequencer_if.sv - word handshake and selector outputs of the mux sequencer
interface mux_sequencer_if;
    logic [3:0] iData;
    logic       iStart;
    logic       oReady;
    logic [3:0] oData;
    logic [1:0] oSelector;
    logic       oBitStrobe;
    logic       oBusy;
    logic       oDone;

    modport slave (
        input  iData,
        input  iStart,
        output oReady,
        output oData,
        output oSelector,
        output oBitStrobe,
        output oBusy,
        output oDone
    );

    modport master (
        output iData,
        output iStart,
        input  oReady,
        input  oData,
        input  oSelector,
        input  oBitStrobe,
        input  oBusy,
        input  oDone
    );
endinterface

// File: rtl/mux_sequencer.sv
// rtl/mux_sequencer.sv - steps a 4:1 mux selector through a captured word, CLKS_PER_BIT cycles per index
module mux_sequencer #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          MSB_FIRST    = 1'b0
) (
    input  logic            iClk,
    input  logic            iRst_n,
    mux_sequencer_if.slave  bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]    SEL_FIRST = MSB_FIRST ? 2'b11 : 2'b00;
    localparam logic [1:0]    SEL_LAST  = MSB_FIRST ? 2'b00 : 2'b11;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    data_q, data_d;
    logic [1:0]    sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          strobe_q, strobe_d;
    // Holds oReady low until the first edge after reset release.
    logic          armed_q, armed_d;

    logic ready;
    logic accept;
    logic bit_end;
    logic last_bit;

    assign ready    = (state_q == IDLE) && armed_q;
    assign accept   = ready && bus.iStart;
    assign bit_end  = (cnt_q == CNT_MAX);
    assign last_bit = (sel_q == SEL_LAST);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q  <= IDLE;
            data_q   <= 4'b0000;
            sel_q    <= 2'b00;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            armed_q  <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SEND;
            SEND:    if (bit_end && last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        armed_d  = 1'b1;
        data_d   = data_q;
        sel_d    = 2'b00;
        cnt_d    = '0;
        strobe_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d   = bus.iData;
                    sel_d    = SEL_FIRST;
                    strobe_d = 1'b1;
                end
            end
            SEND: begin
                if (!bit_end) begin
                    sel_d = sel_q;
                    cnt_d = cnt_q + CW'(1);
                end else if (!last_bit) begin
                    sel_d    = MSB_FIRST ? (sel_q - 2'd1) : (sel_q + 2'd1);
                    strobe_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.oReady     = ready;
        bus.oData      = data_q;
        bus.oSelector  = sel_q;
        bus.oBitStrobe = strobe_q;
        bus.oBusy      = (state_q == SEND) || (state_q == DONE);
        bus.oDone      = (state_q == DONE);
    end
endmodule
